// File: rtl/upper_stream_arbiter.sv
// upper_stream_arbiter
// Two byte-stream requesters share one lowercase-to-uppercase converter.
// Whole strings are granted round-robin: IDLE picks an owner, LOCK streams
// that owner's bytes into a single registered, back-pressurable output stage
// until its last byte is accepted.
// Optional build macro: UPPER_STATS_EN adds the str_count / conv_count
// statistics counters and their ports.
module upper_stream_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       in_valid,
    input  logic [15:0]      in_data,
    input  logic [1:0]       in_last,
    output logic [1:0]       in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             out_id,
    input  logic             out_ready,
    output logic             busy
`ifdef UPPER_STATS_EN
    ,
    output logic [CNT_W-1:0] str_count,
    output logic [CNT_W-1:0] conv_count
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    // Arbitration state
    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner;
    logic        w_owner_nxt;
    logic        r_prio;
    logic        w_prio_nxt;

    // Output stage registers
    logic        r_vld_p1;
    logic [7:0]  r_data_p1;
    logic        r_last_p1;
    logic        r_id_p1;

    // Owner-selected input view
    logic        w_slot_free;
    logic        w_req;
    logic [7:0]  w_byte;
    logic        w_last;
    logic        w_accept;

    // True for 'a'..'z'
    function automatic logic is_lower(input logic [7:0] b);
        return (b >= 8'd97) && (b <= 8'd122);
    endfunction

    // Lowercase letters drop by 32; every other byte passes unchanged
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        return is_lower(b) ? (b - 8'd32) : b;
    endfunction

    // Select the owner's byte lane and decide whether it transfers this cycle
    always_comb begin
        w_slot_free = !r_vld_p1 || out_ready;
        w_req       = r_owner ? in_valid[1] : in_valid[0];
        w_byte      = r_owner ? in_data[15:8] : in_data[7:0];
        w_last      = r_owner ? in_last[1] : in_last[0];
        w_accept    = (r_state == S_LOCK) && w_req && w_slot_free;
    end

    // Arbitration state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

    // Next-state logic: grant in IDLE (no byte taken that cycle), release on last byte
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_prio_nxt  = r_prio;
        in_ready    = 2'b00;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid != 2'b00) begin
                    // On contention the favoured channel wins; otherwise the lone requester
                    w_owner_nxt = (in_valid == 2'b11) ? r_prio : in_valid[1];
                    w_state_nxt = S_LOCK;
                end
            end
            S_LOCK: begin
                in_ready = r_owner ? {w_slot_free, 1'b0} : {1'b0, w_slot_free};
                if (w_accept && w_last) begin
                    w_state_nxt = S_IDLE;
                    w_prio_nxt  = ~r_owner;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output stage: load on accept, otherwise drop valid once drained; hold under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= 8'd0;
            r_last_p1 <= 1'b0;
            r_id_p1   <= 1'b0;
        end else if (w_accept) begin
            r_vld_p1  <= 1'b1;
            r_data_p1 <= to_upper(w_byte);
            r_last_p1 <= w_last;
            r_id_p1   <= r_owner;
        end else if (r_vld_p1 && out_ready) begin
            r_vld_p1  <= 1'b0;
        end
    end

`ifdef UPPER_STATS_EN
    logic [CNT_W-1:0] r_str_cnt;
    logic [CNT_W-1:0] r_conv_cnt;

    // Statistics: completed strings and altered bytes, both free-running and wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_str_cnt  <= '0;
            r_conv_cnt <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_str_cnt <= r_str_cnt + 1'b1;
            end
            if (is_lower(w_byte)) begin
                r_conv_cnt <= r_conv_cnt + 1'b1;
            end
        end
    end

    assign str_count  = r_str_cnt;
    assign conv_count = r_conv_cnt;
`endif

    assign out_valid = r_vld_p1;
    assign out_data  = r_data_p1;
    assign out_last  = r_last_p1;
    assign out_id    = r_id_p1;
    assign busy      = (r_state == S_LOCK);

endmodule

// File: doc/upper_stream_arbiter.md
# upper_stream_arbiter

Shares a single ASCII lowercase-to-uppercase conversion datapath between two byte-stream requesters. Each requester presents a string as a valid/ready byte stream terminated by a `last` flag. The block grants one whole string at a time with round-robin fairness and converts every byte. It emits the result on one registered, back-pressurable output stream tagged with the source ID. It sits between the string producers and the downstream character sink.

## Interface
- `CNT_W`, default 16: width of the statistics counters.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 2: per-channel byte valid; bit k is channel k.
- `in_data` input 16: per-channel byte; `[8k+7:8k]` is channel k.
- `in_last` input 2: per-channel end-of-string flag, qualified by `in_valid`.
- `in_ready` output 2: per-channel accept; a byte is transferred when `in_valid[k] & in_ready[k]`.
- `out_valid` output 1: output byte valid.
- `out_data` output 8: converted byte.
- `out_last` output 1: last byte of the string.
- `out_id` output 1: source channel of `out_data`.
- `out_ready` input 1: downstream accept.
- `busy` output 1: high while a string is granted (state LOCK).
- `str_count` output CNT_W: strings completed (present only with `UPPER_STATS_EN`).
- `conv_count` output CNT_W: bytes altered by conversion (present only with `UPPER_STATS_EN`).

## Operation
- **Conversion rule**
  - Byte 97..122 ('a'..'z') maps to byte−32.
  - All other bytes 0..255 pass unchanged, including 65..90, 123..127 and 128..255.
- **FSM states:** IDLE, LOCK. Registered state: `owner` (1 bit) and `prio` (1 bit, the favoured channel).
- **IDLE**
  - If exactly one channel has `in_valid` high, set `owner` to that channel and go to LOCK.
  - If both are high, set `owner` to `prio` and go to LOCK.
  - If neither is high, stay in IDLE.
  - `in_ready` = 0 in IDLE. No byte is accepted in the grant cycle.
- **LOCK**
  - `in_ready[owner] = slot_free`, where `slot_free = !out_valid | out_ready`. `in_ready` of the non-owner is 0.
  - On an accepted byte, load the output register with the converted byte, `in_last[owner]` and `owner`, and set `out_valid` = 1.
  - If the accepted byte has `last` = 1: go to IDLE and set `prio` to `~owner`.
- **Output register**
  - If `out_valid & out_ready` and no new byte is loaded, clear `out_valid`.
  - A simultaneous drain and load keeps `out_valid` = 1 with the new byte.
- Strings are never interleaved on the output. A granted string holds the datapath until its last byte is accepted, however long the owner stalls.
- A grant with `in_valid` dropping afterwards is legal. The block stays in LOCK waiting for the owner.
- A string of length 1 (first byte has `last`) is legal.

## Timing
- **Reset values:** `in_ready` = 0, `out_valid` = 0, `out_data` = 0, `out_last` = 0, `out_id` = 0, `busy` = 0, state IDLE, `owner` = 0, `prio` = 0, counters 0.
- **Assertion of `rst_n`** at any time, including mid-string, clears all of the above immediately. The partial string is discarded, and the requester re-sends it from the start.
- **Latency**
  - A byte accepted at edge N is visible on `out_*` after edge N.
  - The first byte of a string is accepted no earlier than the edge after the grant edge.
- **Throughput:** 1 byte/cycle within a string while `out_ready` = 1. There is exactly one idle input cycle (the IDLE grant cycle) between consecutive strings.
- **Output stability:** `out_*` hold stable while `out_valid & !out_ready`.
- **`in_ready` dependency:** `in_ready` depends combinationally on `out_ready`. There is no other combinational input-to-output path.

## Configuration
- **`UPPER_STATS_EN` defined**
  - `str_count` increments on acceptance of every byte with `last`.
  - `conv_count` increments on every accepted byte in 97..122.
  - Both wrap modulo 2^CNT_W and clear only on reset.
- **`UPPER_STATS_EN` undefined:** the ports and counters are absent. All other behaviour is identical.

## Test plan
- **Single byte:** reset, then ch0 sends 97 with `last` and `out_ready` = 1. Grant occurs at edge 1 and acceptance at edge 2. After edge 2: `out_data` = 65, `out_last` = 1, `out_id` = 0. `busy` returns to 0 after edge 2.
- **Conversion vectors:** ch1 sends the string 40, 72, 183, 131, 124, 20, 235, 97, 65, 122, 71, 109, 146, 48, 207, 58, 123, 148, 127 (last on 127). Output must be 40, 72, 183, 131, 124, 20, 235, 65, 65, 90, 71, 77, 146, 48, 207, 58, 123, 148, 127, back-to-back with `out_id` = 1.
- **Contention and fairness:** after reset, both channels hold 3-byte strings valid. Output is all ch0 bytes and then all ch1 bytes, with no interleave. A following simultaneous request grants ch0 again, because `prio` returned to 0 after ch1's string completed.
- **Back-pressure:** hold `out_ready` = 0 for 5 cycles mid-string. `out_*` are stable, `in_ready` = 0, and after release every byte appears exactly once, in order.
- **Reset mid-string:** pulse `rst_n` low after 2 of 4 bytes. All outputs are 0 immediately, the state is IDLE, and a new string from ch1 is granted normally.
- **Statistics (`UPPER_STATS_EN`):** ch0 sends 97, 66, 123, 122 with last on 122. After completion: `str_count` = 1, `conv_count` = 2.
